// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between a load/store unit (master) and the data
// memory responder (slave).
//   data_req     master->slave  request, held with its fields until data_valid
//   data_addr    master->slave  byte address
//   data_we      master->slave  1 = store, 0 = load
//   wdata        master->slave  store data
//   byte_enable  master->slave  per-lane store enable
//   data_valid   slave->master  one-cycle completion pulse
//   rdata        slave->master  load data (valid with data_valid)
//   data_err     slave->master  out-of-range flag (valid with data_valid)
//   busy         slave->master  request in flight
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
);
    logic                       data_req;
    logic [DATA_WIDTH-1:0]      data_addr;
    logic                       data_we;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [BYTE_DATA_WIDTH-1:0] byte_enable;
    logic                       data_valid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       data_err;
    logic                       busy;

    modport master (
        output data_req, data_addr, data_we, wdata, byte_enable,
        input  data_valid, rdata, data_err, busy
    );

    modport slave (
        input  data_req, data_addr, data_we, wdata, byte_enable,
        output data_valid, rdata, data_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-port word-organised data RAM answering one load/store at a time with
// a fixed latency. Completion is signalled by a one-cycle data_valid pulse.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (RAM contents are not cleared)
//   bus  dmem_responder_if.slave request/response bundle
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int ADDR_BITS       = 10,
    parameter int LATENCY         = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Counter preload so that S_RESP is reached exactly LATENCY cycles after acceptance.
    localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                     state_r;
    logic [3:0]                 cnt_r;
    logic [ADDR_BITS-1:0]       idx_r;
    logic                       we_r;
    logic                       oor_r;
    logic [DATA_WIDTH-1:0]      wdata_r;
    logic [BYTE_DATA_WIDTH-1:0] be_r;

    logic                       valid_r;
    logic [DATA_WIDTH-1:0]      rdata_r;
    logic                       derr_r;
    logic                       busy_r;

    logic [DATA_WIDTH-1:0]      mem_r [0:DEPTH-1];

    logic [ADDR_BITS-1:0]       req_idx_s;
    logic                       req_oor_s;
    logic                       unused_addr_s;

    // Decode word index and range check of the incoming address.
    always_comb begin
        req_idx_s = bus.data_addr[ADDR_BITS+1:2];
        req_oor_s = |bus.data_addr[DATA_WIDTH-1:ADDR_BITS+2];
    end

    // Byte offset within a word is deliberately ignored.
    assign unused_addr_s = ^bus.data_addr[1:0];

    // Request FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            we_r    <= 1'b0;
            oor_r   <= 1'b0;
            wdata_r <= '0;
            be_r    <= '0;
            valid_r <= 1'b0;
            rdata_r <= '0;
            derr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    valid_r <= 1'b0;
                    rdata_r <= '0;
                    derr_r  <= 1'b0;
                    if (bus.data_req) begin
                        idx_r   <= req_idx_s;
                        we_r    <= bus.data_we;
                        oor_r   <= req_oor_s;
                        wdata_r <= bus.wdata;
                        be_r    <= bus.byte_enable;
                        busy_r  <= 1'b1;
                        if (LATENCY == 1) begin
                            // Response built straight from the live request fields.
                            state_r <= S_RESP;
                            valid_r <= 1'b1;
                            derr_r  <= req_oor_s;
                            rdata_r <= (!bus.data_we && !req_oor_s) ? mem_r[req_idx_s] : '0;
                        end else begin
                            state_r <= S_BUSY;
                            cnt_r   <= LAT_INIT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (cnt_r == 4'd0) begin
                        // The RAM read here sees every earlier store: they commit
                        // before the idle gap that separates requests.
                        state_r <= S_RESP;
                        valid_r <= 1'b1;
                        derr_r  <= oor_r;
                        rdata_r <= (!we_r && !oor_r) ? mem_r[idx_r] : '0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    state_r <= S_IDLE;
                    valid_r <= 1'b0;
                    rdata_r <= '0;
                    derr_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= 4'd0;
                    valid_r <= 1'b0;
                    rdata_r <= '0;
                    derr_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Store commit at the edge ending S_RESP; reset or out-of-range drops it.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == S_RESP) && we_r && !oor_r) begin
            for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_valid = valid_r;
    assign bus.rdata      = rdata_r;
    assign bus.data_err   = derr_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Main instance uses LATENCY=2; two extra
// instances (LATENCY=1 and LATENCY=4) exercise continuous-request throughput.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) b2 ();
    dmem_responder_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) b1 ();
    dmem_responder_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) b4 ();

    dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .ADDR_BITS(10), .LATENCY(2))
        dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .ADDR_BITS(10), .LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    dmem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .ADDR_BITS(10), .LATENCY(4))
        dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

    // Issue one request on the LATENCY=2 instance; report latency (negedges after
    // the request cycle), response fields, and data_valid in the following cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] rd,
                         output logic er, output logic vafter);
        int k;
        @(posedge clk);
        #1;
        b2.data_req    = 1'b1;
        b2.data_we     = we;
        b2.data_addr   = addr;
        b2.wdata       = wd;
        b2.byte_enable = be;
        k = 0;
        @(negedge clk);
        while (b2.data_valid !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        rd  = b2.rdata;
        er  = b2.data_err;
        @(posedge clk);
        #1;
        b2.data_req = 1'b0;
        @(negedge clk);
        vafter = b2.data_valid;
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({b2.data_valid, b2.rdata, b2.data_err, b2.busy} !== 35'd0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: valid=%b rdata=%h err=%b busy=%b expected all 0",
                         i, b2.data_valid, b2.rdata, b2.data_err, b2.busy);
            end
        end
        // Request held high across reset.
        @(posedge clk);
        #1;
        rst          = 1'b1;
        b2.data_req  = 1'b1;
        b2.data_we   = 1'b0;
        b2.data_addr = 32'h0000_0000;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (b2.data_valid !== 1'b0 || b2.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_req: valid=%b busy=%b expected 0 0", b2.data_valid, b2.busy);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        @(negedge clk);
        while (b2.data_valid !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checks++;
                if (b2.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_wait: busy=%b expected 1", b2.busy);
                end
            end
        end
        checks++;
        if (k !== 2) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d expected 2", k);
        end
        checks++;
        if (b2.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_resp: busy=%b expected 1", b2.busy);
        end
        @(posedge clk);
        #1;
        b2.data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.data_valid !== 1'b0 || b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_resp_idle: valid=%b busy=%b expected 0 0", b2.data_valid, b2.busy);
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; logic va;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0 || va !== 1'b0) begin
            errors++;
            $display("FAIL store_full: lat=%0d rdata=%h err=%b vafter=%b expected 2 00000000 0 0", lat, rd, er, va);
        end
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || va !== 1'b0) begin
            errors++;
            $display("FAIL load_0x10: lat=%0d rdata=%h err=%b vafter=%b expected 2 deadbeef 0 0", lat, rd, er, va);
        end
        issue(1'b0, 32'h0000_0013, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL load_0x13: lat=%0d rdata=%h err=%b expected 2 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_partial_store();
        int lat; logic [31:0] rd; logic er; logic va;
        issue(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_be2: lat=%0d rdata=%h err=%b expected 2 00000000 0", lat, rd, er);
        end
        issue(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, lat, rd, er, va);
        checks++;
        if (lat !== 2 || er !== 1'b0 || va !== 1'b0) begin
            errors++;
            $display("FAIL store_be0: lat=%0d err=%b vafter=%b expected 2 0 0", lat, er, va);
        end
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (rd !== 32'hDEAD_AAEF) begin
            errors++;
            $display("FAIL partial_load: rdata=%h expected deadaaef", rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er; logic va;
        issue(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, lat, rd, er, va);
        issue(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL oor_store: lat=%0d rdata=%h err=%b expected 2 00000000 1", lat, rd, er);
        end
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL oor_load: lat=%0d rdata=%h err=%b expected 2 00000000 1", lat, rd, er);
        end
        issue(1'b0, 32'h0000_0000, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            errors++;
            $display("FAIL word0_unchanged: rdata=%h err=%b expected cafef00d 0", rd, er);
        end
    endtask

    task automatic test_reset_busy();
        int lat; logic [31:0] rd; logic er; logic va;
        issue(1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, lat, rd, er, va);
        @(posedge clk);
        #1;
        b2.data_req    = 1'b1;
        b2.data_we     = 1'b1;
        b2.data_addr   = 32'h0000_0020;
        b2.wdata       = 32'h5555_5555;
        b2.byte_enable = 4'hF;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        b2.data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.data_valid !== 1'b0 || b2.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: valid=%b busy=%b expected 0 1", b2.data_valid, b2.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({b2.data_valid, b2.rdata, b2.data_err, b2.busy} !== 35'd0) begin
                errors++;
                $display("FAIL post_reset_quiet cycle %0d: valid=%b rdata=%h err=%b busy=%b expected all 0",
                         i, b2.data_valid, b2.rdata, b2.data_err, b2.busy);
            end
        end
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rd, er, va);
        checks++;
        if (lat !== 2 || rd !== 32'h1111_1111) begin
            errors++;
            $display("FAIL dropped_store: lat=%0d rdata=%h expected 2 11111111", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] v1, v4, e1, e4;
        for (int k = 0; k < 15; k++) begin
            e1[k] = ((k % 2) == 1);
            e4[k] = ((k % 5) == 4);
        end
        @(posedge clk);
        #1;
        b1.data_req = 1'b1; b1.data_we = 1'b0; b1.data_addr = 32'h0000_0004;
        b4.data_req = 1'b1; b4.data_we = 1'b0; b4.data_addr = 32'h0000_0004;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            v1[k] = b1.data_valid;
            v4[k] = b4.data_valid;
        end
        @(posedge clk);
        #1;
        b1.data_req = 1'b0;
        b4.data_req = 1'b0;
        checks++;
        if (v1 !== e1) begin
            errors++;
            $display("FAIL throughput_lat1: pattern=%b expected %b", v1, e1);
        end
        checks++;
        if (v4 !== e4) begin
            errors++;
            $display("FAIL throughput_lat4: pattern=%b expected %b", v4, e4);
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (b1.busy !== 1'b0 || b4.busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: busy1=%b busy4=%b expected 0 0", b1.busy, b4.busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        b2.data_req = 1'b0; b2.data_we = 1'b0; b2.data_addr = 32'h0; b2.wdata = 32'h0; b2.byte_enable = 4'h0;
        b1.data_req = 1'b0; b1.data_we = 1'b0; b1.data_addr = 32'h0; b1.wdata = 32'h0; b1.byte_enable = 4'h0;
        b4.data_req = 1'b0; b4.data_we = 1'b0; b4.data_addr = 32'h0; b4.wdata = 32'h0; b4.byte_enable = 4'h0;
        test_reset();
        test_store_load();
        test_partial_store();
        test_out_of_range();
        test_reset_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-cache request interface: a single-port, word-organised data RAM serving one outstanding load/store at a time.
- Holds requests with a fixed, parameterised latency and returns one data_valid pulse per request.
- Stands in for the data cache in core-level simulation and small FPGA builds; sits directly on the load/store unit's data_req/data_valid port.

Parameters:
- DATA_WIDTH, 32, word width in bits; must equal 8*BYTE_DATA_WIDTH.
- BYTE_DATA_WIDTH, 4, number of byte lanes / byte-enable bits.
- ADDR_BITS, 10, log2 of RAM depth in words (1024 words).
- LATENCY, 2, cycles from request acceptance to data_valid; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- data_req  input  1  request; initiator holds it and all request fields stable until it sees data_valid.
- data_addr  input  DATA_WIDTH  byte address.
- data_we  input  1  1 = store, 0 = load.
- wdata  input  DATA_WIDTH  store data.
- byte_enable  input  BYTE_DATA_WIDTH  per-lane store enable; ignored for loads.
- data_valid  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  load data, meaningful only while data_valid=1.
- data_err  output  1  out-of-range access flag, meaningful only while data_valid=1.
- busy  output  1  high in S_BUSY and S_RESP.

Behaviour:
- Reset values: state S_IDLE; data_valid, rdata, data_err, busy all 0; latency counter 0.
- RAM contents are not reset.
- Reset asserted mid-operation: next cycle is S_IDLE with all outputs 0. A pending store is dropped; the RAM is unchanged.
- Word index = data_addr[ADDR_BITS+1:2]; data_addr[1:0] ignored (no misalignment handling).
- Out of range: any bit of data_addr[DATA_WIDTH-1:ADDR_BITS+2] nonzero.
- States: S_IDLE, S_BUSY, S_RESP (2-bit encoding); counter is 4 bits wide.
- S_IDLE:
  - If data_req=1 in cycle t, register addr/we/wdata/byte_enable at the end of cycle t.
  - Go to S_RESP if LATENCY=1; otherwise go to S_BUSY with counter=LATENCY-2.
  - If data_req=0, stay in S_IDLE.
- S_BUSY: decrement the counter each cycle; go to S_RESP when counter=0. data_req is not re-sampled here (initiator holds it).
- S_RESP:
  - data_valid=1 for exactly this one cycle, i.e. cycle t+LATENCY.
  - Next state is always S_IDLE.
- Store: commit happens in the S_RESP cycle and is visible at the clock edge ending that cycle.
  - For each lane i with byte_enable[i]=1, mem[idx][8i+7:8i] <= captured wdata lane i; other lanes unchanged.
  - byte_enable=0 modifies nothing but still completes normally.
  - rdata=0 for stores.
- Load: rdata = full word mem[idx] as of the S_RESP cycle, all lanes. Lane masking is the initiator's job.
- Out-of-range access: data_err=1 with data_valid; store suppressed; rdata=0.
- Outside S_RESP, rdata=0 and data_err=0.
- Back-to-back requests: after S_RESP the block is in S_IDLE. If data_req is still high there, that is a new request. Peak throughput is therefore one request per LATENCY+1 cycles.
- A store followed immediately by a load to the same word returns the stored data; no bypass is needed because of the S_IDLE gap.
- Requests arriving while busy are not possible under the protocol and are not queued.

Test Plan:
- Reset, then idle for 5 cycles -> data_valid, rdata, data_err and busy stay 0. With data_req held 1 during reset, no data_valid occurs until 2 cycles after rst drops (LATENCY=2).
- Store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10 -> data_valid exactly 2 cycles after each request is first seen; load returns 0xDEADBEEF. Load of 0x13 returns the same word.
- Partial stores over 0xDEADBEEF at 0x10: be 0x2 with wdata 0x0000AA00, then be 0x0 with wdata 0xFFFFFFFF -> load returns 0xDEADAAEF.
- Out-of-range store to 0x00001000 (ADDR_BITS=10) with wdata 0x12345678, then load 0x00001000 -> both complete with data_err=1 and rdata=0. Load of 0x0 is unchanged from its prior value.
- Reset pulsed while in S_BUSY on a store of 0x55555555 to 0x20 (previously 0x11111111) -> no data_valid; subsequent load of 0x20 returns 0x11111111.
- Continuous data_req over 3 loads, with LATENCY=1 and LATENCY=4 builds -> data_valid every 2 and every 5 cycles respectively; every pulse is exactly one cycle wide.
